// File: rtl/mdc_frac_reduce.sv
// Reduces a fraction num/den by a precomputed GCD using a bit-serial restoring divider,
// numerator first and then denominator, behind valid/ready handshakes on both sides.
//
// state   | meaning
// IDLE    | waiting for an input pair (ready_o high when enabled)
// DIV_NUM | dividing the captured numerator by the GCD, one quotient bit per cycle
// DIV_DEN | dividing the captured denominator by the GCD
// DONE    | result valid, held until the sink takes it
module mdc_frac_reduce #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enb_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] num_i,
    input  logic [W-1:0] den_i,
    input  logic [W-1:0] gcd_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] num_o,
    output logic [W-1:0] den_o,
    output logic         err_o,
    output logic         ndiv_o
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, DIV_NUM, DIV_DEN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  dvd;
    logic [W-1:0]  rem;
    logic [W-1:0]  gcd_q;
    logic [W-1:0]  den_q;
    logic          nz;

    logic [W:0]    rem_sh;
    logic          ge;
    logic [W-1:0]  rem_nx;
    logic [W-1:0]  dvd_nx;
    logic          last;

    // dvd holds the dividend and collects quotient bits at its LSB as it shifts out;
    // the shifted partial remainder is W+1 bits so the compare cannot overflow.
    always_comb begin
        rem_sh = {rem, dvd[W-1]};
        ge     = (rem_sh >= {1'b0, gcd_q});
        rem_nx = ge ? W'(rem_sh - {1'b0, gcd_q}) : rem_sh[W-1:0];
        dvd_nx = {dvd[W-2:0], ge};
        last   = (cnt == CW'(W-1));
    end

    assign ready_o = enb_i && (state == IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            dvd     <= '0;
            rem     <= '0;
            gcd_q   <= '0;
            den_q   <= '0;
            nz      <= 1'b0;
            valid_o <= 1'b0;
            num_o   <= '0;
            den_o   <= '0;
            err_o   <= 1'b0;
            ndiv_o  <= 1'b0;
        end else if (enb_i) begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        dvd   <= num_i;
                        den_q <= den_i;
                        gcd_q <= gcd_i;
                        rem   <= '0;
                        cnt   <= '0;
                        nz    <= 1'b0;
                        if (gcd_i == '0) begin
                            num_o   <= num_i;
                            den_o   <= den_i;
                            err_o   <= 1'b1;
                            ndiv_o  <= 1'b0;
                            valid_o <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= DIV_NUM;
                        end
                    end
                end
                DIV_NUM: begin
                    if (last) begin
                        num_o <= dvd_nx;
                        nz    <= nz | (rem_nx != '0);
                        dvd   <= den_q;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= DIV_DEN;
                    end else begin
                        dvd <= dvd_nx;
                        rem <= rem_nx;
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV_DEN: begin
                    if (last) begin
                        den_o   <= dvd_nx;
                        nz      <= nz | (rem_nx != '0);
                        ndiv_o  <= nz | (rem_nx != '0);
                        err_o   <= 1'b0;
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end else begin
                        dvd <= dvd_nx;
                        rem <= rem_nx;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdc_frac_reduce.sv
// Directed bench for mdc_frac_reduce (W=8): latency, results, backpressure, stall and reset.
module tb_mdc_frac_reduce;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         enb_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] num_i;
    logic [W-1:0] den_i;
    logic [W-1:0] gcd_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] num_o;
    logic [W-1:0] den_o;
    logic         err_o;
    logic         ndiv_o;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    mdc_frac_reduce #(.W(W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .enb_i   (enb_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .num_i   (num_i),
        .den_i   (den_i),
        .gcd_i   (gcd_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .num_o   (num_o),
        .den_o   (den_o),
        .err_o   (err_o),
        .ndiv_o  (ndiv_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // presents an input pair and returns just after the edge that accepts it
    task automatic start(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] g);
        num_i   = n;
        den_i   = d;
        gcd_i   = g;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        cyc     = 0;
    endtask

    task automatic wait_valid(input string tag, input int exp_cyc);
        while (!valid_o && cyc < 60) tick();
        check(tag, cyc, exp_cyc);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                                input logic e, input logic nd);
        check({tag, ".num"}, num_o, n);
        check({tag, ".den"}, den_o, d);
        check({tag, ".err"}, err_o, e);
        check({tag, ".ndiv"}, ndiv_o, nd);
    endtask

    initial begin
        rst_i   = 1'b1;
        enb_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        num_i   = '0;
        den_i   = '0;
        gcd_i   = '0;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst.valid", valid_o, 0);
        check_result("rst", 0, 0, 0, 0);
        check("rst.ready", ready_o, 1);

        // 12/18 by 6
        start(12, 18, 6);
        check("t1.busy", ready_o, 0);
        wait_valid("t1.latency", 16);
        check_result("t1", 2, 3, 0, 0);
        tick();
        check("t1.valid_drop", valid_o, 0);
        check("t1.ready_back", ready_o, 1);

        // zero GCD passes operands through
        start(12, 18, 0);
        check("t2.valid_now", valid_o, 1);
        check_result("t2", 12, 18, 1, 0);
        tick();
        check("t2.valid_drop", valid_o, 0);

        start(255, 0, 255);
        wait_valid("t3.latency", 16);
        check_result("t3", 1, 0, 0, 0);
        tick();

        start(10, 7, 3);
        wait_valid("t4.latency", 16);
        check_result("t4", 3, 2, 0, 1);
        tick();

        // backpressure with an ignored valid_i pulse
        ready_i = 1'b0;
        start(100, 75, 25);
        wait_valid("t5.latency", 16);
        check_result("t5", 4, 3, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                num_i   = 50;
                den_i   = 40;
                gcd_i   = 10;
                valid_i = 1'b1;
            end
            tick();
            valid_i = 1'b0;
            check("t5.hold_valid", valid_o, 1);
            check("t5.hold_ready", ready_o, 0);
            check("t5.hold_num", num_o, 4);
            check("t5.hold_den", den_o, 3);
        end
        ready_i = 1'b1;
        tick();
        check("t5.valid_drop", valid_o, 0);
        check("t5.ready_back", ready_o, 1);
        start(9, 6, 3);
        wait_valid("t6.latency", 16);
        check_result("t6", 3, 2, 0, 0);
        tick();

        // three stalled cycles inside the numerator division
        start(200, 150, 50);
        tick();
        tick();
        tick();
        enb_i = 1'b0;
        tick();
        tick();
        check("t7.stall_ready", ready_o, 0);
        tick();
        check("t7.stall_valid", valid_o, 0);
        enb_i = 1'b1;
        wait_valid("t7.latency", 19);
        check_result("t7", 4, 3, 0, 0);
        tick();

        // reset during the denominator division aborts the operation
        start(77, 55, 11);
        repeat (10) tick();
        check("t8.num_mid", num_o, 7);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t8.valid", valid_o, 0);
        check_result("t8", 0, 0, 0, 0);
        check("t8.ready", ready_o, 1);
        start(8, 4, 4);
        wait_valid("t9.latency", 16);
        check_result("t9", 2, 1, 0, 0);
        tick();
        check("t9.valid_drop", valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
